debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
- UART-side control block for the MIPS pipeline. It sits between the UART receiver/transmitter pair and the datapath.
- It consumes command bytes from the receiver and gates the datapath through a clock-enable.
- It watches the write-back halt flag. Whenever execution stops, it streams a state dump (PC, cycle count, register file) to the transmitter byte by byte.

Parameters:
- NUM_REGS, 32, number of register-file words dumped (1..32).
- CMD_RUN, 8'h63, command byte for continuous run ('c').
- CMD_STEP, 8'h73, command byte for single step ('s').

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle pulse; rx_data is valid.
- tx_data  out  8  byte to UART transmitter.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start.
- halt_in  in  1  halt flag from the MEM/WB latch.
- pc_in  in  32  current program counter.
- dp_en  out  1  datapath enable (PC, pipeline latches, register file).
- dbg_addr  out  5  register-file debug read address.
- dbg_data  in  32  register-file debug read data, valid 1 cycle after dbg_addr.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE; dp_en=0, tx_start=0, tx_data=0, dbg_addr=0;
  - cycle counter=0; byte/word indices=0.
- States: IDLE, RUN, STEP, LOAD, LATCH, SEND, GAP, HALTED.
- IDLE:
  - rx_valid with CMD_RUN -> RUN.
  - rx_valid with CMD_STEP -> STEP.
  - Any other byte is ignored.
- RUN:
  - dp_en = ~halt_in (combinational), so the datapath is frozen in the same cycle halt_in is seen.
  - halt_in=1 -> LOAD with halt_flag set.
  - rx bytes are ignored.
- STEP: dp_en=1 for exactly one cycle, then LOAD with halt_flag cleared. If halt_in=1 during STEP, halt_flag is set.
- Cycle counter: 32-bit; increments on every cycle with dp_en=1; wraps 0xFFFFFFFF->0; cleared only by reset.
- Dump order: word 0 = pc_in, word 1 = cycle counter, words 2..NUM_REGS+1 = registers 0..NUM_REGS-1. Each word is sent LSB first, so total bytes = 8+4*NUM_REGS (136 at default).
- LOAD:
  - Drives dbg_addr = word_idx-2 for register words (0 otherwise).
  - Next state LATCH.
- LATCH:
  - Captures the selected word into a 32-bit shift register: pc_in, the counter, or dbg_data.
  - PC and counter are snapshotted at LATCH; dp_en is 0 throughout the dump.
  - Next state SEND.
- SEND:
  - Waits until tx_busy=0, then pulses tx_start with tx_data = shift[7:0].
  - Next state GAP.
- GAP:
  - One cycle, so tx_busy becomes valid.
  - Shift register >>8; byte_idx++.
  - byte_idx wraps 3->0 with word_idx++ -> LOAD.
  - Otherwise -> SEND.
- After the final byte's GAP:
  - halt_flag=1 -> HALTED;
  - otherwise -> IDLE.
- HALTED: dp_en=0; all commands ignored until reset.
- rx_valid arriving in any state other than IDLE is dropped; the unit has no command buffering.
- tx_start is never asserted while tx_busy=1 and is never high on two consecutive cycles.
- Reset mid-dump aborts immediately: no further tx_start, state IDLE.

Decomposition:
- Shared package `debug_pkg`: state enum, CMD_RUN/CMD_STEP, DUMP_HDR_WORDS=2.
- One natural sub-module, `dump_serializer`: LOAD/LATCH/SEND/GAP word-to-byte engine with a start/done handshake. The top-level FSM handles command decode, run/step control and the cycle counter.

Test Plan:
- Reset release, no rx -> dp_en=0, tx_start never asserted for 1000 cycles, counter=0.
- rx 0x73 with pc_in=0x00000004 and all regs zero:
  - dp_en high for exactly 1 cycle;
  - 136 bytes sent: 04 00 00 00 01 00 00 00, then 128 x 00;
  - returns to IDLE.
- rx 0x63, halt_in raised 10 cycles after the run starts:
  - dp_en high 10 cycles;
  - counter bytes 0A 00 00 00;
  - ends in HALTED, and a following 0x73 produces no dp_en.
- tx_busy held high 50 cycles after each tx_start -> exactly one tx_start per byte, none while busy, byte order unchanged.
- rx 0x63 sent during a dump, and an unknown byte 0x41 sent in IDLE -> both ignored; dump content and length unchanged.
- reset asserted after byte 20 of a dump -> tx_start stops immediately, outputs return to reset values, and a new 0x73 produces a full 136-byte dump.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the UART debug unit.
// Holds the control/serializer state enums, command bytes and helpers.
package debug_pkg;

    localparam logic [7:0] DEF_CMD_RUN    = 8'h63;
    localparam logic [7:0] DEF_CMD_STEP   = 8'h73;
    localparam int         DUMP_HDR_WORDS = 2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        DUMP,
        HALTED
    } ctrl_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        LOAD,
        LATCH,
        SEND,
        GAP
    } ser_state_e;

    // Register-file address for a dump word; header words map to 0.
    function automatic logic [4:0] reg_addr(input logic [5:0] word);
        logic [5:0] a;
        if (word >= 6'(DUMP_HDR_WORDS)) begin
            a = word - 6'(DUMP_HDR_WORDS);
        end else begin
            a = 6'd0;
        end
        return 5'(a);
    endfunction

endpackage

// File: rtl/dump_serializer.sv
// Word-to-byte dump engine: PC, cycle count, then register file, LSB first.
// Ports: start_i/done_o handshake, pc_i/cnt_i/dbg_data_i sources,
// dbg_addr_o regfile address, tx_data_o/tx_start_o/tx_busy_i to UART tx.
module dump_serializer
    import debug_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    output logic        done_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] cnt_i,
    input  logic [31:0] dbg_data_i,
    output logic [4:0]  dbg_addr_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_busy_i
);

    localparam logic [5:0] LAST_WORD = 6'(NUM_REGS + DUMP_HDR_WORDS - 1);

    ser_state_e  state_q;
    logic [5:0]  word_q;
    logic [5:0]  word_d;
    logic [1:0]  byte_q;
    logic [31:0] shift_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic [4:0]  dbg_addr_q;

    assign word_d     = word_q + 6'd1;
    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign dbg_addr_o = dbg_addr_q;
    // Combinational so the controller leaves DUMP on the last GAP edge.
    assign done_o     = (state_q == GAP) && (byte_q == 2'd3)
                        && (word_q == LAST_WORD);

    // dbg_addr is updated on entry to LOAD, so regfile data is
    // valid one cycle later when LATCH captures it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_q     <= 6'd0;
            byte_q     <= 2'd0;
            shift_q    <= 32'd0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            dbg_addr_q <= 5'd0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        word_q     <= 6'd0;
                        byte_q     <= 2'd0;
                        dbg_addr_q <= 5'd0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    if (word_q == 6'd0) begin
                        shift_q <= pc_i;
                    end else if (word_q == 6'd1) begin
                        shift_q <= cnt_i;
                    end else begin
                        shift_q <= dbg_data_i;
                    end
                    state_q <= SEND;
                end
                SEND: begin
                    if (!tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= shift_q[7:0];
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    shift_q <= shift_q >> 8;
                    byte_q  <= byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if (word_q == LAST_WORD) begin
                            state_q <= S_IDLE;
                        end else begin
                            word_q     <= word_d;
                            dbg_addr_q <= reg_addr(word_d);
                            state_q    <= LOAD;
                        end
                    end else begin
                        state_q <= SEND;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_unit.sv
// UART debug controller: decodes run/step commands, gates the datapath
// and dumps PC, cycle count and registers whenever execution stops.
// Ports: rx_data/rx_valid from UART rx, tx_data/tx_start/tx_busy to
// UART tx, halt_in/pc_in/dbg_data from datapath, dp_en/dbg_addr to it.
module debug_unit
    import debug_pkg::*;
#(
    parameter int         NUM_REGS = 32,
    parameter logic [7:0] CMD_RUN  = DEF_CMD_RUN,
    parameter logic [7:0] CMD_STEP = DEF_CMD_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic        halt_in,
    input  logic [31:0] pc_in,
    output logic        dp_en,
    output logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data
);

    ctrl_state_e state_q;
    logic        halt_flag_q;
    logic        start_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        done;

    // Combinational so the datapath freezes in the cycle halt is seen.
    assign dp_en = ((state_q == RUN) && !halt_in) || (state_q == STEP);
    assign cnt_d = dp_en ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            halt_flag_q <= 1'b0;
            start_q     <= 1'b0;
            cnt_q       <= 32'd0;
        end else begin
            start_q <= 1'b0;
            cnt_q   <= cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_RUN) begin
                            state_q <= RUN;
                        end else if (rx_data == CMD_STEP) begin
                            state_q <= STEP;
                        end
                    end
                end
                RUN: begin
                    if (halt_in) begin
                        halt_flag_q <= 1'b1;
                        start_q     <= 1'b1;
                        state_q     <= DUMP;
                    end
                end
                STEP: begin
                    halt_flag_q <= halt_in;
                    start_q     <= 1'b1;
                    state_q     <= DUMP;
                end
                DUMP: begin
                    if (done) begin
                        state_q <= halt_flag_q ? HALTED : IDLE;
                    end
                end
                HALTED: state_q <= HALTED;
                default: state_q <= IDLE;
            endcase
        end
    end

    dump_serializer #(
        .NUM_REGS (NUM_REGS)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_q),
        .done_o     (done),
        .pc_i       (pc_in),
        .cnt_i      (cnt_q),
        .dbg_data_i (dbg_data),
        .dbg_addr_o (dbg_addr),
        .tx_data_o  (tx_data),
        .tx_start_o (tx_start),
        .tx_busy_i  (tx_busy)
    );

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: vector table of run/step scenarios,
// byte scoreboard on the tx side, plus reset and idle corner sequences.
module tb_debug_unit;

    localparam int NREG   = 32;
    localparam int NBYTES = 8 + 4 * NREG;
    localparam int LIMIT  = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        halt_in = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        dp_en;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data = 32'd0;

    always #5 clk = ~clk;

    debug_unit #(.NUM_REGS(NREG)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .halt_in  (halt_in),
        .pc_in    (pc_in),
        .dp_en    (dp_en),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Register file model: synchronous read, one-cycle latency.
    logic [31:0] regs [NREG];
    always @(posedge clk) dbg_data <= regs[dbg_addr];

    // UART transmitter model: busy for busy_len cycles after tx_start.
    int busy_len = 2;
    int bcnt = 0;
    always @(posedge clk) begin
        if (tx_start) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    logic [7:0] expq [$];
    int n_vec = 0;
    int n_err = 0;
    int byte_cnt = 0;
    int dp_cnt = 0;
    logic prev_start = 1'b0;
    logic [31:0] cnt_model = 32'd0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_start) begin
            byte_cnt++;
            n_vec++;
            if (tx_busy || prev_start) begin
                n_err++;
                $display("FAIL tx_handshake byte %0d: busy=%0b prev_start=%0b, required 0 and 0",
                         byte_cnt, tx_busy, prev_start);
            end
            n_vec++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL extra_byte: got %02h, required no byte", tx_data);
            end else begin
                e = expq.pop_front();
                if (tx_data !== e) begin
                    n_err++;
                    $display("FAIL dump_byte %0d: got %02h, required %02h",
                             byte_cnt, tx_data, e);
                end
            end
        end
        if (dp_en) dp_cnt++;
        prev_start = tx_start;
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        halt_in = 1'b0;
        tick(3);
        reset     = 1'b1;
        cnt_model = 32'd0;
        tick(1);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) expq.push_back(w[8*b +: 8]);
    endtask

    task automatic fill_regs(input bit seed);
        for (int i = 0; i < NREG; i++)
            regs[i] = seed ? $urandom() : 32'd0;
    endtask

    task automatic push_dump();
        push_word(pc_in);
        push_word(cnt_model);
        for (int i = 0; i < NREG; i++) push_word(regs[i]);
    endtask

    typedef struct {
        bit          rst;
        logic [7:0]  cmd;
        logic [31:0] pc;
        int          busy;
        bit          halt_pre;
        int          halt_after;
        bit          seed;
        bit          inject;
        int          exp_dp;
        bit          exp_halted;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int b0;
        int d0;
        int cyc;
        bit injected;

        tbl[0] = '{1, 8'h73, 32'h0000_0004,  2, 0,  0, 0, 0,  1, 0};
        tbl[1] = '{0, 8'h73, 32'h1234_5678,  0, 0,  0, 1, 1,  1, 0};
        tbl[2] = '{0, 8'h73, 32'hCAFE_F00D, 50, 0,  0, 1, 0,  1, 0};
        tbl[3] = '{1, 8'h63, 32'h0000_0040,  2, 0, 10, 1, 0, 10, 1};
        tbl[4] = '{1, 8'h73, 32'h0000_0100,  3, 1,  0, 1, 0,  1, 1};

        fill_regs(0);
        tick(3);
        check("rst_dp_en", int'(dp_en), 0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_dbg_addr", int'(dbg_addr), 0);
        reset = 1'b1;

        b0 = byte_cnt;
        d0 = dp_cnt;
        tick(1000);
        check("idle_tx_bytes", byte_cnt - b0, 0);
        check("idle_dp_cycles", dp_cnt - d0, 0);

        b0 = byte_cnt;
        d0 = dp_cnt;
        send_rx(8'h41);
        tick(40);
        check("unknown_cmd_tx", byte_cnt - b0, 0);
        check("unknown_cmd_dp", dp_cnt - d0, 0);

        for (int v = 0; v < 5; v++) begin
            if (tbl[v].rst) do_reset();
            busy_len = tbl[v].busy;
            pc_in    = tbl[v].pc;
            halt_in  = tbl[v].halt_pre;
            fill_regs(tbl[v].seed);
            cnt_model = cnt_model + 32'(tbl[v].exp_dp);
            push_dump();
            b0 = byte_cnt;
            d0 = dp_cnt;
            send_rx(tbl[v].cmd);
            if (tbl[v].cmd == 8'h63) begin
                tick(tbl[v].halt_after);
                halt_in = 1'b1;
            end
            cyc = 0;
            injected = 0;
            while (byte_cnt - b0 < NBYTES && cyc < LIMIT) begin
                tick(1);
                cyc++;
                if (tbl[v].inject && !injected && byte_cnt - b0 >= 5) begin
                    send_rx(8'h63);
                    injected = 1;
                end
            end
            tick(20);
            check($sformatf("v%0d_dump_len", v), byte_cnt - b0, NBYTES);
            check($sformatf("v%0d_drained", v), expq.size(), 0);
            check($sformatf("v%0d_dp_cycles", v), dp_cnt - d0, tbl[v].exp_dp);
            expq.delete();
            if (tbl[v].exp_halted) begin
                b0 = byte_cnt;
                d0 = dp_cnt;
                send_rx(8'h73);
                tick(30);
                check($sformatf("v%0d_halted_dp", v), dp_cnt - d0, 0);
                check($sformatf("v%0d_halted_tx", v), byte_cnt - b0, 0);
            end
        end

        // Reset in the middle of a dump, then a clean full dump.
        do_reset();
        busy_len = 2;
        pc_in = 32'h0000_0200;
        fill_regs(1);
        cnt_model = cnt_model + 32'd1;
        push_dump();
        b0 = byte_cnt;
        send_rx(8'h73);
        cyc = 0;
        while (byte_cnt - b0 < 20 && cyc < LIMIT) begin
            tick(1);
            cyc++;
        end
        reset = 1'b0;
        @(negedge clk);
        check("midrst_tx_start", int'(tx_start), 0);
        check("midrst_dp_en", int'(dp_en), 0);
        check("midrst_tx_data", int'(tx_data), 0);
        check("midrst_dbg_addr", int'(dbg_addr), 0);
        tick(50);
        check("midrst_bytes", byte_cnt - b0, 20);
        expq.delete();
        reset = 1'b1;
        cnt_model = 32'd0;
        tick(2);

        cnt_model = cnt_model + 32'd1;
        push_dump();
        b0 = byte_cnt;
        d0 = dp_cnt;
        send_rx(8'h73);
        cyc = 0;
        while (byte_cnt - b0 < NBYTES && cyc < LIMIT) begin
            tick(1);
            cyc++;
        end
        tick(20);
        check("postrst_dump_len", byte_cnt - b0, NBYTES);
        check("postrst_drained", expq.size(), 0);
        check("postrst_dp_cycles", dp_cnt - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
